hs_ram_arbiter: RTL

HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

---
 rtl/hs_arb_pkg.sv | 22 ++
 rtl/hs_ram_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg
//   Shared definitions for the hiscore / CPU work-RAM arbiter:
//   default parameter values, the arbiter state encoding and the
//   REQ watchdog limit used when HS_ARB_TIMEOUT_EN is defined.
package hs_arb_pkg;

   localparam int HS_ARB_AW_DEF     = 12;
   localparam int HS_ARB_DW_DEF     = 8;
   localparam int HS_ARB_SETTLE_DEF = 2;

   // Number of consecutive REQ cycles without a pause acknowledge
   // before the watchdog abandons the request.
   localparam int TIMEOUT_MAX = 65535;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_GRANT  = 2'd2,
      ST_SETTLE = 2'd3
   } arb_state_t;

endpackage

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter
//   Shares one synchronous work-RAM port between the CPU and the hiscore
//   engine. The hiscore side asks the CPU to pause, takes the port once the
//   pause is acknowledged, and keeps it for SETTLE cycles after its intent
//   drops so trailing accesses complete cleanly.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | CPU owns the RAM port, no pause requested
//   ST_REQ    | pause_req high, waiting for paused
//   ST_GRANT  | hiscore owns the RAM port while intent is held
//   ST_SETTLE | hiscore still owns the port, counting down before release
//
// Ports
//   clk_sys, reset_n                 clock, synchronous active-low reset
//   cpu_addr/cpu_wdata/cpu_we        CPU RAM request
//   hs_address/hs_data_in/
//   hs_write_enable                  hiscore RAM request
//   hs_access_read/hs_access_write   hiscore intent
//   paused                           CPU pause acknowledge
//   ram_rdata                        RAM read data (1-cycle latency)
//   ram_addr/ram_wdata/ram_we        muxed RAM port
//   hs_data_out                      registered read data to hiscore
//   pause_req, hs_grant              arbitration status
//   hs_timeout                       REQ watchdog pulse (HS_ARB_TIMEOUT_EN only)
//
// Build option
//   HS_ARB_TIMEOUT_EN : adds a 16-bit watchdog on ST_REQ and the hs_timeout
//                       output. Undefined: ST_REQ waits indefinitely.
module hs_ram_arbiter
   import hs_arb_pkg::*;
#(
   parameter int AW     = HS_ARB_AW_DEF,
   parameter int DW     = HS_ARB_DW_DEF,
   parameter int SETTLE = HS_ARB_SETTLE_DEF
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          cpu_we,
   input  logic [AW-1:0] hs_address,
   input  logic [DW-1:0] hs_data_in,
   input  logic          hs_write_enable,
   input  logic          hs_access_read,
   input  logic          hs_access_write,
   input  logic          paused,
   input  logic [DW-1:0] ram_rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   output logic [DW-1:0] hs_data_out,
   output logic          pause_req,
   output logic          hs_grant
`ifdef HS_ARB_TIMEOUT_EN
   ,
   output logic          hs_timeout
`endif
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

   arb_state_t  state;
   logic [3:0]  settle_cnt;
   logic        rd_valid;
   logic        intent;

`ifdef HS_ARB_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_MAX - 1);
   logic [15:0] wd_cnt;
`endif

   assign intent    = hs_access_read | hs_access_write;
   assign pause_req = (state != ST_IDLE);
   assign hs_grant  = (state == ST_GRANT) || (state == ST_SETTLE);

   always_comb begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
      if (hs_grant) begin
         ram_addr  = hs_address;
         ram_wdata = hs_data_in;
         ram_we    = hs_write_enable;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         settle_cnt  <= '0;
         rd_valid    <= 1'b0;
         hs_data_out <= '0;
`ifdef HS_ARB_TIMEOUT_EN
         wd_cnt      <= '0;
         hs_timeout  <= 1'b0;
`endif
      end else begin
         // RAM data lags the address by one cycle, so capture on the
         // cycle after a granted address was presented.
         rd_valid <= hs_grant;
         if (rd_valid) begin
            hs_data_out <= ram_rdata;
         end
`ifdef HS_ARB_TIMEOUT_EN
         hs_timeout <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (intent) begin
                  state <= ST_REQ;
`ifdef HS_ARB_TIMEOUT_EN
                  wd_cnt <= '0;
`endif
               end
            end
            ST_REQ: begin
               if (!intent) begin
                  state <= ST_IDLE;
               end else if (paused) begin
                  state <= ST_GRANT;
               end
`ifdef HS_ARB_TIMEOUT_EN
               else if (wd_cnt == WD_LAST) begin
                  state      <= ST_IDLE;
                  hs_timeout <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
               end
`endif
            end
            ST_GRANT: begin
               // Losing paused here is deliberately ignored: the hiscore
               // side keeps the port until it releases its intent.
               if (!intent) begin
                  settle_cnt <= SETTLE_LOAD;
                  state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (intent) begin
                  state <= ST_GRANT;
               end else if (settle_cnt == 4'd0) begin
                  state <= ST_IDLE;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
